// File: rtl/shifter_seq_left_if.sv
// Handshake and operand/result bundle for the multi-cycle left shifter.
// The control unit drives the master side; the shifter is the slave side.
interface shifter_seq_left_if #(
    parameter int DATA_W = 32
);
    logic              start_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic [3:0]        ALUCtrl_i;
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] data_o;

    modport master (
        output start_i, src1_i, src2_i, ALUCtrl_i,
        input  busy_o, done_o, data_o
    );

    modport slave (
        input  start_i, src1_i, src2_i, ALUCtrl_i,
        output busy_o, done_o, data_o
    );
endinterface

// File: rtl/shifter_seq_left.sv
// Multi-cycle logical left shifter (SLL, LUI) with a start/busy/done handshake.
// The working register moves STEP bits per clock; the datapath stalls on busy_o.
// Optional right shifts (SRA, SRL) are compiled in when SHIFTER_RIGHT_EN is defined.
module shifter_seq_left #(
    parameter int DATA_W = 32,
    parameter int STEP   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    shifter_seq_left_if.slave bus
);

    localparam logic [3:0] OP_LUI = 4'b1010;
    localparam logic [3:0] OP_SLL = 4'b1011;
`ifdef SHIFTER_RIGHT_EN
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
`endif

    // Largest move per SHIFT cycle; STEP is one of 1, 2, 4, 8, 16.
    localparam logic [4:0] STEP_AMT = 5'(STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

`ifdef SHIFTER_RIGHT_EN
    typedef enum logic [1:0] {
        DIR_SLL,
        DIR_SRL,
        DIR_SRA
    } dir_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] work_q,  work_d;
    logic [4:0]        rem_q,   rem_d;
    logic [DATA_W-1:0] data_q,  data_d;
`ifdef SHIFTER_RIGHT_EN
    dir_t              dir_q,   dir_d;
    dir_t              cap_dir;
`endif

    logic              cap_ok;
    logic [4:0]        cap_shamt;
    logic              cap_now;
    logic              last_step;
    logic [4:0]        step_amt;
    logic [DATA_W-1:0] shifted;

    // Only the low five bits of the shift-amount source are meaningful.
    logic unused_src2_hi;
    assign unused_src2_hi = ^bus.src2_i[DATA_W-1:5];

    assign cap_now = (state_q == S_IDLE) && bus.start_i;

    // Decode the operation presented with start_i into support flag and shift amount.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        cap_ok    = 1'b0;
        cap_shamt = 5'd0;
`ifdef SHIFTER_RIGHT_EN
        cap_dir   = DIR_SLL;
`endif
        case (bus.ALUCtrl_i)
            OP_LUI: begin
                cap_ok    = 1'b1;
                cap_shamt = 5'd16;
            end
            OP_SLL: begin
                cap_ok    = 1'b1;
                cap_shamt = bus.src2_i[4:0];
            end
`ifdef SHIFTER_RIGHT_EN
            OP_SRA: begin
                cap_ok    = 1'b1;
                cap_shamt = bus.src2_i[4:0];
                cap_dir   = DIR_SRA;
            end
            OP_SRL: begin
                cap_ok    = 1'b1;
                cap_shamt = bus.src2_i[4:0];
                cap_dir   = DIR_SRL;
            end
`endif
            default: begin
                cap_ok    = 1'b0;
                cap_shamt = 5'd0;
            end
        endcase
    end

    // Per-cycle shift: min(STEP, remaining) bits, zero-fill (or sign-fill for SRA).
    always_comb begin
        last_step = (rem_q <= STEP_AMT);
        step_amt  = last_step ? rem_q : STEP_AMT;
`ifdef SHIFTER_RIGHT_EN
        case (dir_q)
            DIR_SRL: shifted = work_q >> step_amt;
            DIR_SRA: shifted = $signed(work_q) >>> step_amt;
            default: shifted = work_q << step_amt;
        endcase
`else
        shifted = work_q << step_amt;
`endif
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            rem_q   <= 5'd0;
            data_q  <= '0;
`ifdef SHIFTER_RIGHT_EN
            dir_q   <= DIR_SLL;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
`ifdef SHIFTER_RIGHT_EN
            dir_q   <= dir_d;
`endif
        end
    end

    // Next-state logic: unsupported or zero-length shifts skip straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (!cap_ok || (cap_shamt == 5'd0)) state_d = S_DONE;
                    else                                state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_step) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture on start, shift while in SHIFT, publish on the final move.
    always_comb begin
        work_d = work_q;
        rem_d  = rem_q;
        data_d = data_q;
`ifdef SHIFTER_RIGHT_EN
        dir_d  = dir_q;
`endif
        if (cap_now) begin
            work_d = cap_ok ? bus.src1_i : '0;
            rem_d  = cap_shamt;
`ifdef SHIFTER_RIGHT_EN
            dir_d  = cap_dir;
`endif
            if (!cap_ok || (cap_shamt == 5'd0)) begin
                data_d = cap_ok ? bus.src1_i : '0;
            end
        end else if (state_q == S_SHIFT) begin
            work_d = shifted;
            rem_d  = rem_q - step_amt;
            if (last_step) begin
                data_d = shifted;
            end
        end
    end

    // Handshake outputs are decoded from the registered state only.
    always_comb begin
        bus.busy_o = (state_q != S_IDLE);
        bus.done_o = (state_q == S_DONE);
    end

    assign bus.data_o = data_q;

endmodule

// File: tb/tb_shifter_seq_left.sv
// Directed bench for shifter_seq_left: one instance with STEP=1, one with STEP=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_shifter_seq_left;

    localparam logic [3:0] OP_LUI = 4'b1010;
    localparam logic [3:0] OP_SLL = 4'b1011;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    shifter_seq_left_if if_a ();
    shifter_seq_left_if if_b ();

    shifter_seq_left #(.DATA_W(32), .STEP(1)) u_dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_a)
    );

    shifter_seq_left #(.DATA_W(32), .STEP(4)) u_dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int sel, input logic st, input logic [3:0] op,
                         input logic [31:0] s1, input logic [31:0] s2);
        if (sel == 0) begin
            if_a.start_i = st; if_a.ALUCtrl_i = op; if_a.src1_i = s1; if_a.src2_i = s2;
        end else begin
            if_b.start_i = st; if_b.ALUCtrl_i = op; if_b.src1_i = s1; if_b.src2_i = s2;
        end
    endtask

    task automatic sample(input int sel, output logic b, output logic d, output logic [31:0] q);
        if (sel == 0) begin
            b = if_a.busy_o; d = if_a.done_o; q = if_a.data_o;
        end else begin
            b = if_b.busy_o; d = if_b.done_o; q = if_b.data_o;
        end
    endtask

    // Issue one operation on the selected instance and follow it to the first idle cycle.
    // Returns at that idle cycle's falling edge, so the next call starts back to back.
    task automatic run_op(input int sel, input logic [3:0] op, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [31:0] exp_data,
                          input int exp_k, input int intr_cyc, input string name);
        int          busy_cnt;
        int          done_cnt;
        int          done_cyc;
        logic [31:0] done_data;
        logic        b;
        logic        d;
        logic [31:0] q;
        busy_cnt  = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        done_data = 32'hxxxx_xxxx;
        b = 1'b0; d = 1'b0; q = 32'h0;
        drive(sel, 1'b1, op, s1, s2);
        @(negedge clk);
        // Operands change right after capture; the result must not follow them.
        drive(sel, 1'b0, 4'b1111, ~s1, ~s2);
        for (int c = 0; c <= exp_k + 1; c++) begin
            sample(sel, b, d, q);
            if (b) busy_cnt++;
            if (d) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc  = c;
                    done_data = q;
                end
            end
            if (c == intr_cyc)          drive(sel, 1'b1, OP_LUI, 32'h0000_5555, 32'h0);
            else if (c == intr_cyc + 1) drive(sel, 1'b0, 4'b1111, 32'h0, 32'h0);
            if (c != exp_k + 1) @(negedge clk);
        end
        total++;
        if ((done_cnt !== 1) || (done_cyc !== exp_k)) begin
            $display("FAIL %s[%0d] done timing: pulses=%0d first_cycle=%0d, want pulses=1 cycle=%0d",
                     name, sel, done_cnt, done_cyc, exp_k);
        end else passed++;
        total++;
        if (busy_cnt !== exp_k + 1) begin
            $display("FAIL %s[%0d] busy length: got %0d cycles, want %0d", name, sel, busy_cnt, exp_k + 1);
        end else passed++;
        total++;
        if (done_data !== exp_data) begin
            $display("FAIL %s[%0d] data at done: got %h, want %h", name, sel, done_data, exp_data);
        end else passed++;
        total++;
        if ({b, d, q} !== {1'b0, 1'b0, exp_data}) begin
            $display("FAIL %s[%0d] idle hold: busy=%b done=%b data=%h, want busy=0 done=0 data=%h",
                     name, sel, b, d, q, exp_data);
        end else passed++;
    endtask

    task automatic test_reset;
        logic b; logic d; logic [31:0] q;
        rst = 1'b0;
        drive(0, 1'b0, 4'b0000, 32'h0, 32'h0);
        drive(1, 1'b0, 4'b0000, 32'h0, 32'h0);
        #2 rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(s, b, d, q);
            total++;
            if ({b, d, q} !== 34'h0) begin
                $display("FAIL reset[%0d] outputs: busy=%b done=%b data=%h, want 0 0 0", s, b, d, q);
            end else passed++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sample(s, b, d, q);
            total++;
            if ({b, d, q} !== 34'h0) begin
                $display("FAIL reset_release[%0d] outputs: busy=%b done=%b data=%h, want 0 0 0", s, b, d, q);
            end else passed++;
        end
    endtask

    task automatic test_sll_basic;
        run_op(0, OP_SLL, 32'h0000_0001, 32'd5, 32'h0000_0020, 5, -1, "sll5");
        run_op(1, OP_SLL, 32'h0000_0001, 32'd5, 32'h0000_0020, 2, -1, "sll5");
    endtask

    task automatic test_lui;
        run_op(0, OP_LUI, 32'h0000_ABCD, 32'h0, 32'hABCD_0000, 16, -1, "lui");
        run_op(1, OP_LUI, 32'h0000_ABCD, 32'h0, 32'hABCD_0000, 4, -1, "lui");
    endtask

    task automatic test_right;
`ifdef SHIFTER_RIGHT_EN
        run_op(0, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 4, -1, "sra4");
        run_op(0, OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 4, -1, "srl4");
        run_op(1, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, -1, "sra4");
        run_op(1, OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1, -1, "srl4");
`else
        run_op(0, OP_SRA, 32'h8000_0000, 32'd4, 32'h0000_0000, 0, -1, "sra_off");
        run_op(0, OP_LUI, 32'h0000_0001, 32'd0, 32'h0001_0000, 16, -1, "lui_fill");
        run_op(0, OP_SRL, 32'h8000_0000, 32'd4, 32'h0000_0000, 0, -1, "srl_off");
        run_op(1, OP_SRA, 32'h8000_0000, 32'd4, 32'h0000_0000, 0, -1, "sra_off");
        run_op(1, OP_LUI, 32'h0000_0001, 32'd0, 32'h0001_0000, 4, -1, "lui_fill");
        run_op(1, OP_SRL, 32'h8000_0000, 32'd4, 32'h0000_0000, 0, -1, "srl_off");
`endif
    endtask

    task automatic test_zero_unsup;
        for (int s = 0; s < 2; s++) begin
            run_op(s, OP_SLL, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 0, -1, "sll0");
            run_op(s, OP_ADD, 32'h1234_5678, 32'd3, 32'h0000_0000, 0, -1, "unsup");
        end
    endtask

    task automatic test_back_to_back;
        run_op(0, OP_SLL, 32'hFFFF_FFFF, 32'd31, 32'h8000_0000, 31, 10, "sll31_busy");
        run_op(0, OP_SLL, 32'h0000_0003, 32'd2, 32'h0000_000C, 2, -1, "after_done");
        run_op(1, OP_SLL, 32'hFFFF_FFFF, 32'd31, 32'h8000_0000, 8, 5, "sll31_busy");
        run_op(1, OP_SLL, 32'h0000_0003, 32'd2, 32'h0000_000C, 1, -1, "after_done");
    endtask

    task automatic test_reset_abort;
        logic b; logic d; logic [31:0] q;
        int   late_done;
        int   late_busy;
        drive(0, 1'b1, OP_SLL, 32'h0000_0001, 32'd20);
        drive(1, 1'b1, OP_SLL, 32'h0000_0001, 32'd20);
        @(negedge clk);
        drive(0, 1'b0, OP_SLL, 32'h0000_0001, 32'd20);
        drive(1, 1'b0, OP_SLL, 32'h0000_0001, 32'd20);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(s, b, d, q);
            total++;
            if ({b, d, q} !== 34'h0) begin
                $display("FAIL abort[%0d] outputs: busy=%b done=%b data=%h, want 0 0 0", s, b, d, q);
            end else passed++;
        end
        @(negedge clk);
        rst = 1'b0;
        late_done = 0;
        late_busy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                sample(s, b, d, q);
                if (d) late_done++;
                if (b) late_busy++;
            end
        end
        total++;
        if ({late_done, late_busy} !== {32'd0, 32'd0}) begin
            $display("FAIL abort_after: done pulses=%0d busy cycles=%0d, want 0 and 0", late_done, late_busy);
        end else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_sll_basic();
        test_lui();
        test_right();
        test_zero_unsup();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Backstop so the run always terminates even if a task stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule
